huff_bit_window_feeder: RTL and testbench

- Upstream stage of the Huffman decoder.
- Accepts the compressed stream as bytes over a valid/ready handshake and holds them in an MSB-first bit buffer.
- Presents a 6-bit left-aligned window of the next unconsumed bits.
- Advances by the decoder-reported symbol length (1..6) on each consume pulse.
- Zero-pads the tail after the final byte and flags completion.

---
 rtl/huff_bit_window_feeder.sv | 131 +++++++++++++
 tb/tb_huff_bit_window_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/huff_bit_window_feeder.sv
// Huffman decoder front end: packs incoming bytes MSB-first into a bit buffer and
// presents a left-aligned window. Optional macro HUFF_FEEDER_BITCNT_EN adds consumed_bits.
module huff_bit_window_feeder #(
  parameter int IN_W  = 8,
  parameter int WIN_W = 6,
  parameter int BUF_W = 16,  // must be >= IN_W + WIN_W
  parameter int LEN_W = 4,
  localparam int CNT_W = $clog2(BUF_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WIN_W-1:0]  win_data,
  output logic              win_valid,
  output logic [CNT_W-1:0]  win_bits,
  input  logic              consume,
  input  logic [LEN_W-1:0]  consume_len,
  output logic              done,
  output logic              err
`ifdef HUFF_FEEDER_BITCNT_EN
  ,
  output logic [15:0]       consumed_bits
`endif
);

  typedef enum logic [1:0] {FILL, STREAM, DRAIN, DONE} state_e;

  localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(BUF_W - IN_W);
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN_W);
  localparam logic [CNT_W-1:0] IN_CNT   = CNT_W'(IN_W);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIN_W);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   bitbuf_q, bitbuf_d, shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_mid, len_ext;
  logic               last_seen_q, last_seen_d;
  logic               err_q, err_d;
  logic               legal, accept;

  assign in_ready  = (cnt_q <= ROOM_MAX) && !last_seen_q && (state_q != DONE);
  assign win_valid = (state_q != DONE) &&
                     ((cnt_q >= WIN_CNT) || (last_seen_q && (cnt_q != '0)));
  assign win_data  = bitbuf_q[BUF_W-1 -: WIN_W];
  assign win_bits  = cnt_q;
  assign done      = (state_q == DONE);
  assign err       = err_q;

  assign len_ext = CNT_W'(consume_len);
  assign legal   = consume && win_valid && (consume_len != '0) &&
                   (consume_len <= LEN_MAX) && (len_ext <= cnt_q);
  assign accept  = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    shifted     = bitbuf_q;
    cnt_mid     = cnt_q;
    last_seen_d = last_seen_q;
    state_d     = state_q;

    // Shift out consumed bits first so a same-cycle byte lands after the survivors.
    if (legal) begin
      shifted = bitbuf_q << consume_len;
      cnt_mid = cnt_q - len_ext;
    end

    bitbuf_d = shifted;
    cnt_d    = cnt_mid;
    if (accept) begin
      bitbuf_d    = shifted | ({in_data, {(BUF_W-IN_W){1'b0}}} >> cnt_mid);
      cnt_d       = cnt_mid + IN_CNT;
      last_seen_d = last_seen_q | in_last;
    end

    err_d = err_q | (consume && !legal);

    case (state_q)
      FILL: begin
        if (last_seen_d)            state_d = DRAIN;
        else if (cnt_d >= WIN_CNT)  state_d = STREAM;
      end
      STREAM: begin
        if (last_seen_d)            state_d = DRAIN;
        else if (cnt_d < WIN_CNT)   state_d = FILL;
      end
      DRAIN: begin
        if (cnt_d == '0)            state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = FILL;
    endcase
  end

  // NOTE: the bit buffer is an ordinary register, so it is cleared on reset like any flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      bitbuf_q    <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      bitbuf_q    <= bitbuf_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
    end
  end

`ifdef HUFF_FEEDER_BITCNT_EN
  logic [15:0] consumed_bits_q, consumed_bits_d;

  // Only legal consumes count; none are legal in DONE, so the count freezes there.
  always_comb begin
    consumed_bits_d = consumed_bits_q;
    if (legal) consumed_bits_d = consumed_bits_q + 16'(consume_len);
  end

  always_ff @(posedge clk) begin
    if (!rst) consumed_bits_q <= '0;
    else      consumed_bits_q <= consumed_bits_d;
  end

  assign consumed_bits = consumed_bits_q;
`endif

endmodule

// File: tb/tb_huff_bit_window_feeder.sv
// Self-checking bench for huff_bit_window_feeder: directed scenarios then random traffic,
// compared against a bit-queue reference model.
module tb_huff_bit_window_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [5:0]  win_data;
  logic        win_valid;
  logic [4:0]  win_bits;
  logic        consume = 1'b0;
  logic [3:0]  consume_len = '0;
  logic        done;
  logic        err;
`ifdef HUFF_FEEDER_BITCNT_EN
  logic [15:0] consumed_bits;
`endif

  huff_bit_window_feeder dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .win_data(win_data), .win_valid(win_valid), .win_bits(win_bits),
    .consume(consume), .consume_len(consume_len),
    .done(done), .err(err)
`ifdef HUFF_FEEDER_BITCNT_EN
    , .consumed_bits(consumed_bits)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the unconsumed stream as a queue of bits, oldest first.
  bit          mq[$];
  bit          m_last, m_done, m_err;
  int unsigned m_consumed;

  function automatic bit m_ready();
    return (mq.size() <= 8) && !m_last && !m_done;
  endfunction

  function automatic bit m_win_valid();
    return !m_done && ((mq.size() >= 6) || (m_last && mq.size() > 0));
  endfunction

  function automatic logic [5:0] m_win();
    logic [5:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) if (i < mq.size()) w[5-i] = mq[i];
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = 0; m_done = 0; m_err = 0; m_consumed = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic l,
                            input logic c, input logic [3:0] len);
    bit rdy, wv, lg;
    int n;
    rdy = m_ready();
    wv  = m_win_valid();
    n   = mq.size();
    lg  = c && wv && (len >= 1) && (len <= 6) && (int'(len) <= n);
    if (c && !lg) m_err = 1;
    if (lg) begin
      repeat (int'(len)) void'(mq.pop_front());
      m_consumed += len;
    end
    if (v && rdy) begin
      for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
      if (l) m_last = 1;
    end
    if (m_last && mq.size() == 0) m_done = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".win_data"},  32'(win_data),  32'(m_win()));
    check({tag, ".win_valid"}, 32'(win_valid), 32'(m_win_valid()));
    check({tag, ".win_bits"},  32'(win_bits),  32'(mq.size()));
    check({tag, ".in_ready"},  32'(in_ready),  32'(m_ready()));
    check({tag, ".done"},      32'(done),      32'(m_done));
    check({tag, ".err"},       32'(err),       32'(m_err));
`ifdef HUFF_FEEDER_BITCNT_EN
    check({tag, ".consumed"},  32'(consumed_bits), m_consumed & 32'hFFFF);
`endif
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic l,
                      input logic c, input logic [3:0] len);
    in_valid = v; in_data = d; in_last = l; consume = c; consume_len = len;
    check({tag, ".ready_pre"}, 32'(in_ready), 32'(m_ready()));
    @(posedge clk);
    model_step(v, d, l, c, len);
    #1;
    in_valid = 0; in_last = 0; consume = 0; consume_len = '0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 0; in_valid = 0; consume = 0; in_last = 0;
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset("rst0");
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_win_data", 32'(win_data), 32'd0);
    step("idle", 0, 8'h00, 0, 0, 4'd0);

    // Single byte then a 1-bit consume.
    step("acc_a5", 1, 8'hA5, 0, 0, 4'd0);
    check("a5_bits", 32'(win_bits), 32'd8);
    check("a5_data", 32'(win_data), 32'h29);
    check("a5_valid", 32'(win_valid), 32'd1);
    step("cons1", 0, 8'h00, 0, 1, 4'd1);
    check("c1_bits", 32'(win_bits), 32'd7);
    check("c1_data", 32'(win_data), 32'h12);

    // Simultaneous accept and consume from cnt=8.
    do_reset("rst1");
    step("acc_a5b", 1, 8'hA5, 0, 0, 4'd0);
    step("simul", 1, 8'h3C, 0, 1, 4'd6);
    check("simul_bits", 32'(win_bits), 32'd10);
    check("simul_data", 32'(win_data), 32'h13);

    // Backpressure at cnt=9.
    step("to9", 0, 8'h00, 0, 1, 4'd1);
    check("bp_bits9", 32'(win_bits), 32'd9);
    check("bp_ready0", 32'(in_ready), 32'd0);
    step("bp_hold", 1, 8'h5A, 0, 0, 4'd0);
    check("bp_not_taken", 32'(win_bits), 32'd9);
    step("bp_cons", 1, 8'h5A, 0, 1, 4'd1);
    check("bp_ready1", 32'(in_ready), 32'd1);
    step("bp_take", 1, 8'h5A, 0, 0, 4'd0);
    check("bp_bits16", 32'(win_bits), 32'd16);

    // Illegal lengths 0 and 7.
    step("ill0", 0, 8'h00, 0, 1, 4'd0);
    check("ill0_err", 32'(err), 32'd1);
    check("ill0_bits", 32'(win_bits), 32'd16);
    step("ill7", 0, 8'h00, 0, 1, 4'd7);
    check("ill7_bits", 32'(win_bits), 32'd16);
    step("to10", 0, 8'h00, 0, 1, 4'd6);
    check("mid_bits10", 32'(win_bits), 32'd10);
    do_reset("rst_mid");
    check("mid_err_clr", 32'(err), 32'd0);
    check("mid_bits0", 32'(win_bits), 32'd0);

    // Tail drain to DONE.
    step("last_ff", 1, 8'hFF, 1, 0, 4'd0);
    check("ff_bits", 32'(win_bits), 32'd8);
    check("ff_ready", 32'(in_ready), 32'd0);
    step("tail6", 0, 8'h00, 0, 1, 4'd6);
    check("tail6_bits", 32'(win_bits), 32'd2);
    check("tail6_valid", 32'(win_valid), 32'd1);
    check("tail6_data", 32'(win_data), 32'h30);
    step("tail2", 0, 8'h00, 0, 1, 4'd2);
    check("tail2_done", 32'(done), 32'd1);
    check("tail2_ready", 32'(in_ready), 32'd0);
    check("tail2_err", 32'(err), 32'd0);
    step("cons_done", 0, 8'h00, 0, 1, 4'd1);
    check("done_err", 32'(err), 32'd1);
    check("done_held", 32'(done), 32'd1);

    // Over-long consume of a 3-bit tail.
    do_reset("rst2");
    step("last_c3", 1, 8'hC3, 1, 0, 4'd0);
    step("c3_5", 0, 8'h00, 0, 1, 4'd5);
    step("c3_ill", 0, 8'h00, 0, 1, 4'd5);
    check("c3_err", 32'(err), 32'd1);
    check("c3_bits", 32'(win_bits), 32'd3);
    check("c3_data", 32'(win_data), 32'h18);
`ifdef HUFF_FEEDER_BITCNT_EN
    check("c3_consumed", 32'(consumed_bits), 32'd5);
`endif
    step("c3_fin", 0, 8'h00, 0, 1, 4'd3);
    check("c3_done", 32'(done), 32'd1);
`ifdef HUFF_FEEDER_BITCNT_EN
    check("c3_consumed8", 32'(consumed_bits), 32'd8);
`endif

    // Random traffic.
    do_reset("rst_rand");
    for (int i = 0; i < 3000; i++) begin
      logic       v, l, c;
      logic [7:0] d;
      logic [3:0] len;
      if (m_done || $urandom_range(0, 299) == 0) do_reset("rnd_rst");
      v   = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      l   = ($urandom_range(0, 15) == 0);
      c   = ($urandom_range(0, 1) == 1);
      len = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'($urandom_range(1, 6));
      step("rnd", v, d, l, c, len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
